// File: rtl/unpack_operands_pkg.sv
// Shared types and constants for the single-precision operand unpacker.
// Holds the FSM encoding, IEEE754 field constants and the mantissa load helper.
package unpack_operands_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int          BIAS      = 127;
    localparam logic [7:0]  EXP_ONES  = 8'hFF;
    localparam logic [31:0] CANON_NAN = 32'h7FFF_FFFF;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
    } flags_t;

    // Zero loads an empty mantissa; subnormals load without the hidden bit.
    function automatic logic [23:0] load_man(input logic [31:0] word,
                                             input flags_t      cls,
                                             input logic        subnormal);
        if (cls.zero) begin
            return '0;
        end
        return {~subnormal, word[22:0]};
    endfunction

endpackage

// File: rtl/unpack_operands_checkspecial.sv
// Combinational IEEE754 single-precision classifier: {zero, inf, nan} plus a
// subnormal indication for the normalizer.
module checkspecial
    import unpack_operands_pkg::*;
(
    input  logic [31:0] operand,
    output flags_t      flags,
    output logic        subnormal
);

    logic [7:0]  exp_field;
    logic [22:0] frac_field;
    logic        frac_zero;

    assign exp_field  = operand[30:23];
    assign frac_field = operand[22:0];
    assign frac_zero  = (frac_field == '0);

    always_comb begin
        flags.nan  = (exp_field == EXP_ONES) && !frac_zero;
        flags.inf  = (exp_field == EXP_ONES) &&  frac_zero;
        flags.zero = (exp_field == 8'h00)    &&  frac_zero;
        subnormal  = (exp_field == 8'h00)    && !frac_zero;
    end

endmodule

// File: rtl/unpack_operands.sv
// Captures a dividend/divisor pair, classifies both operands and normalizes
// subnormals one bit per cycle before presenting them to the divider core.
module unpack_operands
    import unpack_operands_pkg::*;
#(
    parameter int EXPW = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in1,
    input  logic [31:0]     in2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            sign1,
    output logic            sign2,
    output logic [EXPW-1:0] exp1,
    output logic [EXPW-1:0] exp2,
    output logic [23:0]     man1,
    output logic [23:0]     man2,
    output logic [2:0]      flags1,
    output logic [2:0]      flags2,
    output logic            sign_q
);

    localparam logic [EXPW-1:0] EXP_ONE = EXPW'(1);

    state_t state, state_nxt;
    flags_t cls1, cls2;
    logic   is_sub1, is_sub2;
    logic   sub1, sub2;
    logic   accept;
    logic   norm_last;

    checkspecial u_cs1 (
        .operand   (in1),
        .flags     (cls1),
        .subnormal (is_sub1)
    );

    checkspecial u_cs2 (
        .operand   (in2),
        .flags     (cls2),
        .subnormal (is_sub2)
    );

    assign accept = in_valid && in_ready;

    // Last NORM cycle: this cycle's shift (or none) leaves every marked
    // operand with its hidden bit set.
    assign norm_last = (!sub1 || man1[23] || man1[22]) &&
                       (!sub2 || man2[23] || man2[22]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_nxt = (is_sub1 || is_sub2) ? S_NORM : S_DONE;
                end
            end
            S_NORM: begin
                if (norm_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign1  <= 1'b0;
            sign2  <= 1'b0;
            exp1   <= '0;
            exp2   <= '0;
            man1   <= '0;
            man2   <= '0;
            flags1 <= '0;
            flags2 <= '0;
            sub1   <= 1'b0;
            sub2   <= 1'b0;
        end else if (accept) begin
            sign1  <= in1[31];
            sign2  <= in2[31];
            flags1 <= cls1;
            flags2 <= cls2;
            sub1   <= is_sub1;
            sub2   <= is_sub2;
            man1   <= load_man(in1, cls1, is_sub1);
            man2   <= load_man(in2, cls2, is_sub2);
            exp1   <= is_sub1 ? EXP_ONE : EXPW'(in1[30:23]);
            exp2   <= is_sub2 ? EXP_ONE : EXPW'(in2[30:23]);
        end else if (state == S_NORM) begin
            if (sub1 && !man1[23]) begin
                man1 <= {man1[22:0], 1'b0};
                exp1 <= exp1 - EXP_ONE;
            end
            if (sub2 && !man2[23]) begin
                man2 <= {man2[22:0], 1'b0};
                exp2 <= exp2 - EXP_ONE;
            end
        end
    end

    assign sign_q = sign1 ^ sign2;

endmodule

// File: tb/tb_unpack_operands.sv
// Scoreboard bench for unpack_operands: the driver queues hand-computed
// expectations, an independent monitor checks every out_valid cycle.
module tb_unpack_operands;

    localparam int EXPW = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in1 = '0;
    logic [31:0]     in2 = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic            sign1, sign2, sign_q;
    logic [EXPW-1:0] exp1, exp2;
    logic [23:0]     man1, man2;
    logic [2:0]      flags1, flags2;

    unpack_operands #(.EXPW(EXPW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign1     (sign1),
        .sign2     (sign2),
        .exp1      (exp1),
        .exp2      (exp2),
        .man1      (man1),
        .man2      (man2),
        .flags1    (flags1),
        .flags2    (flags2),
        .sign_q    (sign_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s1, s2;
        logic [9:0]  e1, e2;
        logic [23:0] m1, m2;
        logic [2:0]  f1, f2;
        logic        sq;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   held    = 1'b0;
    bit   has_cur = 1'b0;
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    endtask

    function automatic exp_t mk(input logic s1, input logic s2,
                                input logic [9:0] e1, input logic [9:0] e2,
                                input logic [23:0] m1, input logic [23:0] m2,
                                input logic [2:0] f1, input logic [2:0] f2,
                                input logic sq, input int lat);
        exp_t e;
        e.s1 = s1; e.s2 = s2; e.e1 = e1; e.e2 = e2; e.m1 = m1; e.m2 = m2;
        e.f1 = f1; e.f2 = f2; e.sq = sq; e.lat = lat; e.acc = 0;
        return e;
    endfunction

    // Monitor: pops on the first cycle of each out_valid and rechecks every
    // held cycle against the same expectation.
    always @(negedge clk) begin
        if (out_valid) begin
            if (!held) begin
                held = 1'b1;
                if (sb.size() == 0) begin
                    has_cur = 1'b0;
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    cur = sb.pop_front();
                    has_cur = 1'b1;
                    check("latency", 32'(cyc - cur.acc + 1), 32'(cur.lat));
                end
            end
            if (has_cur) begin
                check("sign1",  32'(sign1),  32'(cur.s1));
                check("sign2",  32'(sign2),  32'(cur.s2));
                check("exp1",   32'(exp1),   32'(cur.e1));
                check("exp2",   32'(exp2),   32'(cur.e2));
                check("man1",   32'(man1),   32'(cur.m1));
                check("man2",   32'(man2),   32'(cur.m2));
                check("flags1", 32'(flags1), 32'(cur.f1));
                check("flags2", 32'(flags2), 32'(cur.f2));
                check("sign_q", 32'(sign_q), 32'(cur.sq));
            end
        end else begin
            held = 1'b0;
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input bit push,
                        input exp_t e, output int acc_c);
        int w;
        in1 = a;
        in2 = b;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            acc_c = -1;
            return;
        end
        acc_c = cyc + 1;
        e.acc = acc_c;
        if (push) sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb.size() != 0 || out_valid) && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_signs"},     32'({sign1, sign2, sign_q}), 32'd0);
        check({tag, "_exps"},      32'({exp1, exp2}), 32'd0);
        check({tag, "_man1"},      32'(man1), 32'd0);
        check({tag, "_man2"},      32'(man2), 32'd0);
        check({tag, "_flags"},     32'({flags1, flags2}), 32'd0);
    endtask

    exp_t v_one_two, v_sub_min, v_nan_zero, v_inf_sub, v_two_sub, v_cnan_zero, v_pi;
    int   acc_a, acc_b, acc_c, acc_d;

    initial begin
        v_one_two   = mk(0, 0, 10'h07F, 10'h080, 24'h800000, 24'h800000, 3'b000, 3'b000, 0, 1);
        v_sub_min   = mk(0, 0, 10'h3EA, 10'h07F, 24'h800000, 24'h800000, 3'b000, 3'b000, 0, 24);
        v_nan_zero  = mk(0, 1, 10'h0FF, 10'h000, 24'hC00000, 24'h000000, 3'b001, 3'b100, 1, 1);
        v_inf_sub   = mk(1, 0, 10'h0FF, 10'h000, 24'h800000, 24'h800000, 3'b010, 3'b000, 1, 2);
        v_two_sub   = mk(0, 1, 10'h3EB, 10'h3FF, 24'hC00000, 24'h800000, 3'b000, 3'b000, 1, 23);
        v_cnan_zero = mk(0, 0, 10'h0FF, 10'h000, 24'hFFFFFF, 24'h000000, 3'b001, 3'b100, 0, 1);
        v_pi        = mk(0, 0, 10'h080, 10'h07F, 24'hC90FDB, 24'h800000, 3'b000, 3'b000, 0, 1);

        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        send(32'h3F800000, 32'h40000000, 1, v_one_two,   acc_a);
        send(32'h00000001, 32'h3F800000, 1, v_sub_min,   acc_a);
        send(32'h7FC00000, 32'h80000000, 1, v_nan_zero,  acc_a);
        send(32'hFF800000, 32'h00400000, 1, v_inf_sub,   acc_a);
        send(32'h00000003, 32'h80200000, 1, v_two_sub,   acc_a);
        send(32'h7FFFFFFF, 32'h00000000, 1, v_cnan_zero, acc_a);
        drain();

        // back-to-back normal pairs must be taken every second cycle
        send(32'h3F800000, 32'h40000000, 1, v_one_two,   acc_a);
        send(32'h7FC00000, 32'h80000000, 1, v_nan_zero,  acc_b);
        send(32'h7FFFFFFF, 32'h00000000, 1, v_cnan_zero, acc_c);
        send(32'h40490FDB, 32'h3F800000, 1, v_pi,        acc_d);
        check("accept_spacing_1", 32'(acc_b - acc_a), 32'd2);
        check("accept_spacing_2", 32'(acc_c - acc_b), 32'd2);
        check("accept_spacing_3", 32'(acc_d - acc_c), 32'd2);
        drain();

        // downstream stall with a competing request pending
        out_ready = 1'b0;
        send(32'h40490FDB, 32'h3F800000, 1, v_pi, acc_a);
        begin
            int w;
            w = 0;
            while (!out_valid && w < 50) begin
                @(negedge clk);
                w++;
            end
        end
        check("stall_valid_seen", 32'(out_valid), 32'd1);
        in1 = 32'h3F800000;
        in2 = 32'h40000000;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("stall_no_recapture", 32'(sb.size()), 32'd0);

        // reset in the 10th NORM cycle drops the pair
        send(32'h00000001, 32'h3F800000, 0, v_sub_min, acc_a);
        repeat (9) @(negedge clk);
        check("norm_in_ready", 32'(in_ready), 32'd0);
        check("norm_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_idle("norm_reset");
        rst = 1'b0;
        repeat (40) @(negedge clk);

        send(32'h7FC00000, 32'h80000000, 1, v_nan_zero, acc_a);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
